// File: rtl/muldiv_pkg.sv
// Shared types for the sequential M-extension multiply/divide unit:
// funct3 operation encoding, FSM states and operand-sign helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic signed_a(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic signed_b(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Sequential RISC-V M-extension unit: one shift-add / restoring-divide step
// per cycle on operand magnitudes, sign fixed up on the way into DONE.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state;
  op_e               op;
  logic              neg;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] sr;
  logic [CW-1:0]     cnt;

  op_e             f_in;
  logic            sa_in, sb_in, neg_in, start_ok, fast;
  logic [XLEN-1:0] mag_a_in, mag_b_in, fast_res;

  assign f_in     = op_e'(funct3);
  assign sa_in    = signed_a(f_in) & op_a[XLEN-1];
  assign sb_in    = signed_b(f_in) & op_b[XLEN-1];
  assign mag_a_in = sa_in ? '0 - op_a : op_a;
  assign mag_b_in = sb_in ? '0 - op_b : op_b;
  assign neg_in   = is_rem(f_in) ? sa_in : (sa_in ^ sb_in);
  assign start_ok = (state == IDLE) && start && !flush;
  assign busy     = start_ok || (state == CALC);

  // Divide-by-zero and signed overflow resolve straight from the operands.
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (is_div(f_in) && op_b == '0) begin
      fast     = 1'b1;
      fast_res = f_in[1] ? op_a : '1;
    end else if ((f_in == OP_DIV || f_in == OP_REM) && op_a == INT_MIN && op_b == '1) begin
      fast     = 1'b1;
      fast_res = f_in[1] ? '0 : op_a;
    end
  end

  logic [XLEN:0]     mul_sum, trial;
  logic              ge;
  logic [XLEN-1:0]   rem_n, quo, remd, fin;
  logic [2*XLEN-1:0] sr_next, prod_s;

  // sr holds {hi, lo}: product shifts right through it; for divide it is
  // {partial remainder, dividend/quotient} shifting left.
  always_comb begin
    mul_sum = {1'b0, sr[2*XLEN-1:XLEN]} + (sr[0] ? {1'b0, mag_b} : '0);
    trial   = sr[2*XLEN-1:XLEN-1];
    ge      = trial >= {1'b0, mag_b};
    rem_n   = ge ? (trial[XLEN-1:0] - mag_b) : trial[XLEN-1:0];
    sr_next = is_div(op) ? {rem_n, sr[XLEN-2:0], ge} : {mul_sum, sr[XLEN-1:1]};
    prod_s  = neg ? '0 - sr_next : sr_next;
    quo     = sr_next[XLEN-1:0];
    remd    = sr_next[2*XLEN-1:XLEN];
    unique case (op)
      OP_MUL:                        fin = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin = neg ? '0 - quo : quo;
      default:                       fin = neg ? '0 - remd : remd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_MUL;
      neg    <= 1'b0;
      mag_b  <= '0;
      sr     <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          op    <= f_in;
          neg   <= neg_in;
          mag_b <= mag_b_in;
          sr    <= {{XLEN{1'b0}}, mag_a_in};
          cnt   <= '0;
          if (fast) begin
            result <= fast_res;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: if (flush) begin
          state <= IDLE;
        end else begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            result <= fin;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed vectors push expected result
// and completion cycle; a negedge monitor pops them when done pulses.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: cycle %0d result %h, required no done", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result, mon_e.res);
        chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Issue one operation; lat is the cycle (relative to start) at which busy
  // must be low and done expected. poke_at re-asserts start mid-operation.
  task automatic run(input string nm, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                     input int poke_at, input int flush_at, input bit want);
    int   c0;
    exp_t e;
    @(posedge clk); #1;
    c0 = cyc;
    if (want) begin
      e.res = exp_res; e.cyc = c0 + lat; e.name = nm;
      sb.push_back(e);
    end
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      start  = (k == 0) || (k == poke_at);
      funct3 = (k == 0) ? f : 3'b000;
      op_a   = (k == 0) ? a : 32'h0000_1234;
      op_b   = (k == 0) ? b : 32'h0000_0055;
      flush  = (k == flush_at);
      #1;
      chk($sformatf("%s_busy_k%0d", nm, k), {31'b0, busy},
          {31'b0, (k < lat) && !(flush_at >= 0 && k > flush_at)});
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    #1;
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    run("mul_7_neg3",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1, -1, 1);
    run("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1, -1, 1);
    run("mulhsu_m1_2",   3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, -1, -1, 1);
    run("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, -1, -1, 1);
    run("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33,  5, -1, 1);
    run("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, -1, -1, 1);
    run("div_100_m7",    3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, -1, -1, 1);
    run("rem_m100_7",    3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, -1, -1, 1);
    run("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, -1, -1, 1);
    run("remu_9_0",      3'b111, 32'd9,         32'd0,         32'd9,          1, -1, -1, 1);
    run("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          1, -1, -1, 1);
    run("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, -1, -1, 1);
    run("mul_flush_done",3'b000, 32'd3,         32'd5,         32'd15,        33, -1, 33, 1);
    run("div_flushed",   3'b100, 32'd100,       32'd7,         32'h0,         11, -1, 10, 0);
    run("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        33, -1, -1, 1);

    repeat (3) @(posedge clk);
    #1 chk("result_hold", result, 32'd14);

    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd9;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_result", result, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    run("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         33, -1, -1, 1);

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_done: %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an M-extension operation this cycle.
REQ-005 The block SHALL have port funct3, input, 3, the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports op_a and op_b, input, XLEN each, the rs1 and rs2 operands.
REQ-007 The block SHALL have port flush, input, 1, which aborts the operation in flight.
REQ-008 The block SHALL have port busy, output, 1, the EX-stage stall request.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking result as valid.
REQ-010 The block SHALL have port result, output, XLEN, the operation result.

Function
REQ-011 The block SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 In IDLE, start=1 with flush=0 SHALL latch funct3 and operand magnitudes plus sign flags, and the FSM SHALL enter CALC, or DONE on a fast path.
REQ-013 The block SHALL ignore start in CALC and DONE.
REQ-014 CALC SHALL run exactly XLEN iterations, one per cycle, of unsigned shift-add (multiply) or restoring shift-subtract (divide) on the magnitudes, using an iteration counter of $clog2(XLEN)+1 bits.
REQ-015 After the final iteration the FSM SHALL enter DONE, so done asserts XLEN+1 cycles after the start edge.
REQ-016 DONE SHALL last exactly one cycle with done=1, after which the FSM SHALL return to IDLE.
REQ-017 busy SHALL equal (state==IDLE and start and not flush) or (state==CALC), combinationally, and SHALL be 0 in DONE so the pipeline advances while capturing result.
REQ-018 Signs SHALL be handled as follows: MUL/MULH sign both operands, MULHSU signs op_a only, MULHU/DIVU/REMU are unsigned, and the final sign SHALL be applied to the 2*XLEN product, quotient or remainder in DONE.
REQ-019 MUL SHALL return product[XLEN-1:0], and MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-020 The quotient SHALL be negated when the operand signs differ (signed ops), and the remainder SHALL take the sign of op_a.
REQ-021 Divide by zero SHALL take the fast path (IDLE->DONE, done one cycle after start): DIV/DIVU return all ones, and REM/REMU return op_a.
REQ-022 DIV/REM with op_a=1<<(XLEN-1) and op_b=all ones SHALL take the fast path: DIV returns op_a and REM returns 0.
REQ-023 result SHALL hold its value from DONE until the next DONE.
REQ-024 flush=1 in any state SHALL force IDLE on the next edge with no done pulse, and flush has priority over start.
REQ-025 flush during DONE SHALL still let done=1 appear that cycle (already committed), and the next state SHALL be IDLE.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, counter 0, result 0, done 0 and busy 0.
REQ-027 Reset mid-CALC SHALL discard the operation, and the first start after rst falls SHALL run normally.

Structure
REQ-028 Package muldiv_pkg SHALL hold the funct3 operation enum and the FSM state typedef (IDLE, CALC, DONE).
REQ-029 The block SHALL be a single module with no sub-module, with the iteration datapath (accumulator, 2*XLEN shift register, counter) inline.
REQ-030 done/result SHALL be registered, busy SHALL be combinational as REQ-017, and there SHALL be no other combinational input-to-output path.

Verification (XLEN=32)
REQ-031 MUL 7 * 0xFFFFFFFD, start at cycle 0 -> busy high cycles 0-32, done at cycle 33, result 0xFFFFFFEB.
REQ-032 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result 0xFFFFFFFE, and MULHSU 0xFFFFFFFF * 2 -> result 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF, each done at cycle 33.
REQ-034 DIVU 5 / 0 -> done at cycle 1, result 0xFFFFFFFF, and REM 0x80000000 / 0xFFFFFFFF -> done at cycle 1, result 0.
REQ-035 DIV 100/7 with flush at cycle 10 -> no done, busy 0 from cycle 11, and a new DIVU 100/7 started at cycle 12 -> done at cycle 45, result 14.
REQ-036 Reset asserted at cycle 5 of MUL -> outputs 0 immediately, and a subsequent REMU 100/7 -> result 2.
